// File: rtl/vga_heatmap_display.sv
// vga_heatmap_display
//   VGA scan-out engine for the sensor heat-map path. Generates sync timing
//   from the 25 MHz pixel clock. It fetches one sample per displayed cell
//   from frame memory that has a fixed read latency, and maps each sample
//   to RGB through a colormap selected per frame.
//
//   Ports
//     i_clk_25M, i_rst      pixel clock, async active-high reset
//     i_start, i_stop       run control (start pulse, stop at end of frame)
//     i_mode[1:0]           colormap select, latched at frame start
//     i_data[DATA_W-1:0]    sample returned RD_LATENCY clocks after o_addr
//     o_addr, o_addr_valid  cell read address (combinational from counters)
//     o_VGA_*               DAC/connector signals
//     o_frame_done          high during the last clock of each frame
//     o_busy                high while scanning
//
//   State | meaning
//   IDLE  | counters held at 0, syncs high, colour black
//   RUN   | scanning frames continuously
//   STOP  | stop requested; finish the current frame then go IDLE
module vga_heatmap_display #(
  parameter int H_TOTAL    = 800,
  parameter int H_SYNC     = 96,
  parameter int V_TOTAL    = 525,
  parameter int V_SYNC     = 2,
  parameter int X_OFFSET   = 144,
  parameter int Y_OFFSET   = 35,
  parameter int PIX_COLS   = 80,
  parameter int PIX_ROWS   = 60,
  parameter int SCALE_LOG2 = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk_25M,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_addr_valid,
  output logic              o_VGA_CLK,
  output logic              o_VGA_HS,
  output logic              o_VGA_VS,
  output logic              o_VGA_BLANK_N,
  output logic              o_VGA_SYNC_N,
  output logic [7:0]        o_VGA_R,
  output logic [7:0]        o_VGA_G,
  output logic [7:0]        o_VGA_B,
  output logic              o_frame_done,
  output logic              o_busy
);

  localparam int H_W   = $clog2(H_TOTAL + 1);
  localparam int V_W   = $clog2(V_TOTAL + 1);
  localparam int WIN_W = PIX_COLS << SCALE_LOG2;
  localparam int WIN_H = PIX_ROWS << SCALE_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state;
  logic             stop_req;
  logic [1:0]       mode_q;
  logic [H_W-1:0]   h;
  logic [V_W-1:0]   v;
  logic             frame_end;
  logic             stop_next;

  assign frame_end = (state != IDLE) && (h == H_W'(H_TOTAL - 1)) && (v == V_W'(V_TOTAL - 1));
  // A start while a stop is pending cancels it; otherwise the request is sticky.
  assign stop_next = (stop_req && i_start) ? 1'b0 : (stop_req || i_stop);

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      stop_req <= 1'b0;
      mode_q   <= 2'd0;
      h        <= '0;
      v        <= '0;
    end else begin
      case (state)
        IDLE: begin
          h <= '0;
          v <= '0;
          if (i_start) begin
            state    <= i_stop ? STOP : RUN;
            stop_req <= i_stop;
            mode_q   <= i_mode;
          end
        end
        default: begin
          if (h == '0 && v == '0) mode_q <= i_mode;
          stop_req <= stop_next;
          state    <= stop_next ? STOP : RUN;
          if (h == H_W'(H_TOTAL - 1)) begin
            h <= '0;
            if (v == V_W'(V_TOTAL - 1)) v <= '0;
            else                         v <= v + V_W'(1);
          end else begin
            h <= h + H_W'(1);
          end
          if (frame_end && stop_next) begin
            state    <= IDLE;
            stop_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_frame_done = frame_end;
  assign o_busy       = (state != IDLE);

  // Stage 0: window decode and cell address straight from the counters.
  logic           in_win;
  logic [H_W-1:0] hx;
  logic [V_W-1:0] vy;
  logic [H_W-1:0] col;
  logic [V_W-1:0] row;
  logic           hs0;
  logic           vs0;
  logic           chk0;

  assign hx     = h - H_W'(X_OFFSET);
  assign vy     = v - V_W'(Y_OFFSET);
  assign col    = hx >> SCALE_LOG2;
  assign row    = vy >> SCALE_LOG2;
  assign in_win = (state != IDLE) &&
                  (h >= H_W'(X_OFFSET)) && (h < H_W'(X_OFFSET + WIN_W)) &&
                  (v >= V_W'(Y_OFFSET)) && (v < V_W'(Y_OFFSET + WIN_H));
  assign o_addr       = in_win ? (ADDR_W'(row) * ADDR_W'(PIX_COLS) + ADDR_W'(col)) : '0;
  assign o_addr_valid = in_win;
  assign hs0  = (state == IDLE) || (h >= H_W'(H_SYNC));
  assign vs0  = (state == IDLE) || (v >= V_W'(V_SYNC));
  assign chk0 = col[0] ^ row[0];

  // Syncs travel RD_LATENCY+1 stages; window/checker flags only RD_LATENCY,
  // because the RGB register supplies the final stage for colour.
  logic hs_pipe  [0:RD_LATENCY];
  logic vs_pipe  [0:RD_LATENCY];
  logic win_pipe [0:RD_LATENCY-1];
  logic chk_pipe [0:RD_LATENCY-1];

  logic       m;
  logic [7:0] s;
  logic [7:0] t;
  logic [7:0] r_c, g_c, b_c;
  logic       unused_data;

  assign m = i_data[DATA_W-1];
  assign s = i_data[DATA_W-2 -: 8];
  assign t = i_data[DATA_W-1 -: 8];
  assign unused_data = ^i_data;

  always_comb begin
    r_c = 8'd0;
    g_c = 8'd0;
    b_c = 8'd0;
    if (win_pipe[RD_LATENCY-1]) begin
      case (mode_q)
        2'd0: begin
          if (m) begin
            r_c = s;
            g_c = 8'd255 - s;
          end else begin
            g_c = s;
            b_c = 8'd255 - s;
          end
        end
        2'd1: begin
          r_c = t;
          g_c = t;
          b_c = t;
        end
        2'd2: begin
          r_c = t;
          // (t-128)<<1 for t>=128 is just the low 7 bits shifted up.
          g_c = t[7] ? {t[6:0], 1'b0} : 8'd0;
        end
        default: begin
          if (chk_pipe[RD_LATENCY-1]) begin
            r_c = 8'd255;
            g_c = 8'd255;
          end
          b_c = 8'd255;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        hs_pipe[i] <= 1'b1;
        vs_pipe[i] <= 1'b1;
      end
      for (int i = 0; i < RD_LATENCY; i++) begin
        win_pipe[i] <= 1'b0;
        chk_pipe[i] <= 1'b0;
      end
      o_VGA_R <= 8'd0;
      o_VGA_G <= 8'd0;
      o_VGA_B <= 8'd0;
    end else begin
      hs_pipe[0]  <= hs0;
      vs_pipe[0]  <= vs0;
      win_pipe[0] <= in_win;
      chk_pipe[0] <= chk0;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        win_pipe[i] <= win_pipe[i-1];
        chk_pipe[i] <= chk_pipe[i-1];
      end
      o_VGA_R <= r_c;
      o_VGA_G <= g_c;
      o_VGA_B <= b_c;
    end
  end

  assign o_VGA_HS      = hs_pipe[RD_LATENCY];
  assign o_VGA_VS      = vs_pipe[RD_LATENCY];
  assign o_VGA_CLK     = i_clk_25M;
  assign o_VGA_BLANK_N = 1'b1;
  assign o_VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_heatmap_display.sv
// Bench for vga_heatmap_display: two instances (read latency 1 and 3) on a
// shrunken raster so whole frames fit in a short run. A frame-position model
// predicts stage-0 values; pin expectations are those values delayed by
// latency+1 clocks and mapped through the colormap rules.
module tb_vga_heatmap_display;

  localparam int HT = 100, HSY = 12, VT = 40, VSY = 2;
  localparam int XO = 20, YO = 5, COLS = 16, ROWS = 8, SC = 2;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic hs; logic vs; logic win; logic chk; logic [1:0] mode; logic [19:0] addr;
  } rec_t;
  localparam rec_t IDLE_REC = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 20'h0};

  logic clk = 1'b0;
  logic rst, start, stop;
  logic [1:0] mode_in;
  logic [15:0] data1, data3, p3a, p3b;
  logic [19:0] addr1, addr3;
  logic val1, val3, vclk1, vclk3, hs1, hs3, vs1, vs3, bn1, bn3, sn1, sn3;
  logic [7:0] r1, g1, b1, r3, g3, b3;
  logic fd1, fd3, busy1, busy3;

  logic [15:0] mem [0:127];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  int   m_t = 0;
  bit   m_busy = 0, m_pend = 0, m_nxt = 0;
  logic [1:0] m_mode = 2'd0;
  rec_t hist [0:4];

  logic [23:0] lit0 [4];

  vga_heatmap_display #(.H_TOTAL(HT), .H_SYNC(HSY), .V_TOTAL(VT), .V_SYNC(VSY),
    .X_OFFSET(XO), .Y_OFFSET(YO), .PIX_COLS(COLS), .PIX_ROWS(ROWS), .SCALE_LOG2(SC),
    .DATA_W(16), .ADDR_W(20), .RD_LATENCY(1)) u1 (
    .i_clk_25M(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode_in),
    .i_data(data1), .o_addr(addr1), .o_addr_valid(val1), .o_VGA_CLK(vclk1),
    .o_VGA_HS(hs1), .o_VGA_VS(vs1), .o_VGA_BLANK_N(bn1), .o_VGA_SYNC_N(sn1),
    .o_VGA_R(r1), .o_VGA_G(g1), .o_VGA_B(b1), .o_frame_done(fd1), .o_busy(busy1));

  vga_heatmap_display #(.H_TOTAL(HT), .H_SYNC(HSY), .V_TOTAL(VT), .V_SYNC(VSY),
    .X_OFFSET(XO), .Y_OFFSET(YO), .PIX_COLS(COLS), .PIX_ROWS(ROWS), .SCALE_LOG2(SC),
    .DATA_W(16), .ADDR_W(20), .RD_LATENCY(3)) u3 (
    .i_clk_25M(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_mode(mode_in),
    .i_data(data3), .o_addr(addr3), .o_addr_valid(val3), .o_VGA_CLK(vclk3),
    .o_VGA_HS(hs3), .o_VGA_VS(vs3), .o_VGA_BLANK_N(bn3), .o_VGA_SYNC_N(sn3),
    .o_VGA_R(r3), .o_VGA_G(g3), .o_VGA_B(b3), .o_frame_done(fd3), .o_busy(busy3));

  initial forever #20 clk = ~clk;

  // Frame memory with fixed read latency (1 and 3 clocks).
  always @(posedge clk) data1 <= mem[addr1[6:0]];
  always @(posedge clk) begin
    p3a   <= mem[addr3[6:0]];
    p3b   <= p3a;
    data3 <= p3b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t rec_of(input int t, input logic [1:0] md);
    rec_t r;
    int h, v, col, row;
    h = t % HT;
    v = t / HT;
    r = '0;
    r.hs   = (h >= HSY);
    r.vs   = (v >= VSY);
    r.win  = (h >= XO) && (h < XO + COLS * (1 << SC)) && (v >= YO) && (v < YO + ROWS * (1 << SC));
    r.mode = md;
    if (r.win) begin
      col    = (h - XO) / (1 << SC);
      row    = (v - YO) / (1 << SC);
      r.addr = 20'(row * COLS + col);
      r.chk  = ((row + col) % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [23:0] exp_rgb(input rec_t r);
    int d, tt, ss;
    if (!r.win) return 24'h0;
    d  = int'(mem[r.addr[6:0]]);
    tt = d / 256;
    ss = (d / 128) % 256;
    case (r.mode)
      2'd0: return (d >= 32768) ? {8'(ss), 8'(255 - ss), 8'h00} : {8'h00, 8'(ss), 8'(255 - ss)};
      2'd1: return {8'(tt), 8'(tt), 8'(tt)};
      2'd2: return {8'(tt), (tt >= 128) ? 8'((tt - 128) * 2) : 8'h00, 8'h00};
      default: return r.chk ? 24'hFFFFFF : 24'h0000FF;
    endcase
  endfunction

  // Reference model: frame position, run/stop intent and per-frame mode.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_pend = 0; m_t = 0; m_mode = 2'd0;
      for (int i = 0; i < 5; i++) hist[i] = IDLE_REC;
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_pend = stop; m_t = 0; m_mode = mode_in;
        end
      end else begin
        if (m_t == 0) m_mode = mode_in;
        m_nxt  = (m_pend && start) ? 1'b0 : (m_pend || stop);
        m_pend = m_nxt;
        if (m_t == FRAME - 1) begin
          m_t = 0;
          if (m_nxt) begin
            m_busy = 0; m_pend = 0;
          end
        end else begin
          m_t++;
        end
      end
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_busy ? rec_of(m_t, m_mode) : IDLE_REC;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("busy1", 32'(busy1), 32'(m_busy));
      check("busy3", 32'(busy3), 32'(m_busy));
      check("frame_done1", 32'(fd1), 32'(m_busy && m_t == FRAME - 1));
      check("frame_done3", 32'(fd3), 32'(m_busy && m_t == FRAME - 1));
      check("addr1", 32'({val1, addr1}), 32'({hist[0].win, hist[0].addr}));
      check("addr3", 32'({val3, addr3}), 32'({hist[0].win, hist[0].addr}));
      check("sync1", 32'({hs1, vs1}), 32'({hist[2].hs, hist[2].vs}));
      check("sync3", 32'({hs3, vs3}), 32'({hist[4].hs, hist[4].vs}));
      check("rgb1", 32'({r1, g1, b1}), 32'(exp_rgb(hist[2])));
      check("rgb3", 32'({r3, g3, b3}), 32'(exp_rgb(hist[4])));
      check("static_pins", 32'({vclk1, bn1, sn1, vclk3, bn3, sn3}), 32'(6'b010_010));
    end
  end

  task automatic pulse(input bit s, input bit p);
    @(posedge clk); #2;
    start = s; stop = p;
    @(posedge clk); #2;
    start = 0; stop = 0;
  endtask

  task automatic set_mode(input logic [1:0] md);
    @(posedge clk); #2;
    mode_in = md;
  endtask

  task automatic wait_t(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_busy && m_t == target) && n < 10000);
    if (n >= 10000) begin
      checks++;
      errors++;
      $display("FAIL wait_t: frame position %0d not reached within %0d clocks", target, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0000; mem[1] = 16'h7FFF; mem[2] = 16'h8000; mem[3] = 16'hFFFF;
    mem[16] = 16'h8000;
    lit0[0] = 24'h0000FF; lit0[1] = 24'h00FF00; lit0[2] = 24'h00FF00; lit0[3] = 24'hFF0000;
    rst = 0; start = 0; stop = 0; mode_in = 2'd0;
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    cmp_en = 1;

    @(negedge clk);
    check("reset_sync", 32'({hs1, vs1, hs3, vs3}), 32'(4'hF));
    check("reset_rgb", 32'({r1, g1, b1}), 32'(0));
    check("reset_busy", 32'({busy1, fd1, val1}), 32'(0));
    @(posedge clk); #1;
    check("vga_clk_high", 32'({vclk1, vclk3}), 32'(2'b11));

    // Frame 1, mode 0: timing, addresses, literal colours.
    pulse(1, 0);
    wait_t(1);             check("hs_t1", 32'(hs1), 32'(1));
    wait_t(2);             check("hs_t2", 32'(hs1), 32'(0));
    wait_t(HSY + 1);       check("hs_end_low", 32'(hs1), 32'(0));
    wait_t(HSY + 2);       check("hs_rise", 32'(hs1), 32'(1));
    wait_t(2 * HT + 1);    check("vs_line1", 32'(vs1), 32'(0));
    wait_t(2 * HT + 2);    check("vs_rise", 32'(vs1), 32'(1));
    wait_t(YO * HT + XO - 1); check("addr_before_win", 32'({val1, addr1}), 32'(0));
    wait_t(YO * HT + XO);     check("addr_first", 32'({val1, addr1}), 32'({1'b1, 20'd0}));
    wait_t(YO * HT + XO + 4); check("addr_second", 32'({val1, addr1}), 32'({1'b1, 20'd1}));
    for (int c = 0; c < 4; c++) begin
      wait_t(YO * HT + XO + 4 * c + 5);
      check("lit_mode0_l1", 32'({r1, g1, b1}), 32'(lit0[c]));
      check("lit_mode0_l3", 32'({r3, g3, b3}), 32'(lit0[c]));
    end
    wait_t((YO + 4) * HT + XO); check("addr_row1", 32'({val1, addr1}), 32'({1'b1, 20'd16}));
    wait_t(1100);
    set_mode(2'd1);
    wait_t(1225);          check("mode_held_midframe", 32'({r1, g1, b1}), 32'(24'h00FF00));
    wait_t((YO + 31) * HT + XO + 63); check("addr_last", 32'({val1, addr1}), 32'({1'b1, 20'd127}));
    wait_t(FRAME - 2);     check("fd_before_end", 32'(fd1), 32'(0));
    wait_t(FRAME - 1);     check("fd_end", 32'(fd1), 32'(1));

    // Frame 2, mode 1.
    wait_t(YO * HT + XO + 13); check("lit_mode1_gray", 32'({r1, g1, b1}), 32'(24'h808080));
    wait_t(1225);          check("mode1_next_frame", 32'({r1, g1, b1}), 32'(24'h808080));
    wait_t(2000);
    set_mode(2'd3);

    // Frame 3, checkerboard.
    wait_t(YO * HT + XO + 5); check("chk_cell0_l3", 32'({r3, g3, b3}), 32'(24'h0000FF));
    wait_t(YO * HT + XO + 9); check("chk_cell1_l3", 32'({r3, g3, b3}), 32'(24'hFFFFFF));
    check("chk_cell1_l1", 32'({r1, g1, b1}), 32'(24'hFFFFFF));
    wait_t(1500);
    pulse(0, 1);
    wait_t(FRAME - 1);     check("stop_fd", 32'({fd1, busy1}), 32'(2'b11));
    @(negedge clk);
    check("stop_idle", 32'({busy1, busy3}), 32'(0));
    check("stop_pins", 32'({hs1, vs1, r1, g1, b1}), 32'({2'b11, 24'h0}));
    repeat (20) @(negedge clk);

    // Start and stop together: exactly one frame.
    pulse(1, 1);
    wait_t(FRAME - 1);     check("one_frame_fd", 32'(fd3), 32'(1));
    @(negedge clk);        check("one_frame_idle", 32'(busy3), 32'(0));

    // Start during STOP cancels the stop.
    set_mode(2'd2);
    pulse(1, 0);
    wait_t(500);
    pulse(0, 1);
    wait_t(2000);
    pulse(1, 0);
    wait_t(FRAME - 1);
    @(negedge clk);        check("cancel_stays_busy", 32'(busy1), 32'(1));

    // Random control traffic.
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 1499) == 0) || (!m_busy && $urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 5999) == 0);
      if ($urandom_range(0, 699) == 0) mode_in = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #2;
    start = 0; stop = 0;

    // Asynchronous reset in the middle of a line inside the window.
    set_mode(2'd1);
    pulse(1, 0);
    wait_t(2345);
    @(posedge clk); #10;
    rst = 1;
    #1;
    check("arst_l1", 32'({hs1, vs1, r1, g1, b1}), 32'({2'b11, 24'h0}));
    check("arst_l3", 32'({hs3, vs3, r3, g3, b3}), 32'({2'b11, 24'h0}));
    check("arst_ctl", 32'({val1, addr1, fd1, busy1, val3, busy3}), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst = 0;
    pulse(1, 0);
    repeat (5000) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
